// File: rtl/wb_ram_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone arbiter with registered round-robin grant.
// Optional bus-error timeout on stalled transfers is enabled by defining ARB_TIMEOUT_EN.
module wb_ram_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] iwbm_addr_i,
    input  logic        iwbm_cyc_i,
    input  logic        iwbm_stb_i,
    output logic [31:0] iwbm_dat_o,
    output logic        iwbm_ack_o,
    output logic        iwbm_err_o,
    input  logic [31:0] dwbm_addr_i,
    input  logic [31:0] dwbm_dat_i,
    input  logic [3:0]  dwbm_sel_i,
    input  logic        dwbm_cyc_i,
    input  logic        dwbm_stb_i,
    input  logic        dwbm_we_i,
    output logic [31:0] dwbm_dat_o,
    output logic        dwbm_ack_o,
    output logic        dwbm_err_o,
    output logic [31:0] wbs_addr_o,
    output logic [31:0] wbs_dat_o,
    output logic [3:0]  wbs_sel_o,
    output logic        wbs_cyc_o,
    output logic        wbs_stb_o,
    output logic        wbs_we_o,
    input  logic [31:0] wbs_dat_i,
    input  logic        wbs_ack_i,
    input  logic        wbs_err_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_ram_arbiter: TIMEOUT_CYCLES must be within 1..65535");
    end

    typedef enum logic [1:0] {IDLE, BUS_I, BUS_D} state_t;

    state_t state_reg, state_next;
    logic   last_grant_reg, last_grant_next;   // 1 = data master granted last
    logic   req_i, req_d, done, timeout_hit;

    assign req_i = iwbm_cyc_i & iwbm_stb_i;
    assign req_d = dwbm_cyc_i & dwbm_stb_i;
    assign done  = wbs_ack_i | wbs_err_i;

    assign iwbm_dat_o = wbs_dat_i;
    assign dwbm_dat_o = wbs_dat_i;

`ifdef ARB_TIMEOUT_EN
    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic        gnt_stb;

    always_comb begin
        gnt_stb       = 1'b0;
        wait_cnt_next = wait_cnt_reg;
        if (state_reg == BUS_I) begin
            gnt_stb = iwbm_stb_i;
        end else if (state_reg == BUS_D) begin
            gnt_stb = dwbm_stb_i;
        end
        if (state_reg == IDLE || done || timeout_hit) begin
            wait_cnt_next = '0;
        end else if (gnt_stb) begin
            wait_cnt_next = wait_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    assign timeout_hit = (state_reg != IDLE) && (wait_cnt_reg == 16'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Grants are only ever taken from IDLE, so a hand-over always costs one idle cycle.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (req_i && (!req_d || last_grant_reg)) begin
                    state_next      = BUS_I;
                    last_grant_next = 1'b0;
                end else if (req_d) begin
                    state_next      = BUS_D;
                    last_grant_next = 1'b1;
                end
            end
            BUS_I: begin
                if (!iwbm_cyc_i || (done && req_d) || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            BUS_D: begin
                if (!dwbm_cyc_i || (done && req_i) || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wbs_addr_o = '0;
        wbs_dat_o  = '0;
        wbs_sel_o  = '0;
        wbs_cyc_o  = 1'b0;
        wbs_stb_o  = 1'b0;
        wbs_we_o   = 1'b0;
        iwbm_ack_o = 1'b0;
        iwbm_err_o = 1'b0;
        dwbm_ack_o = 1'b0;
        dwbm_err_o = 1'b0;
        case (state_reg)
            BUS_I: begin
                wbs_addr_o = iwbm_addr_i;
                wbs_sel_o  = 4'hF;
                wbs_cyc_o  = iwbm_cyc_i;
                wbs_stb_o  = iwbm_stb_i;
                iwbm_ack_o = wbs_ack_i;
                iwbm_err_o = wbs_err_i | timeout_hit;
            end
            BUS_D: begin
                wbs_addr_o = dwbm_addr_i;
                wbs_dat_o  = dwbm_dat_i;
                wbs_sel_o  = dwbm_sel_i;
                wbs_cyc_o  = dwbm_cyc_i;
                wbs_stb_o  = dwbm_stb_i;
                wbs_we_o   = dwbm_we_i;
                dwbm_ack_o = wbs_ack_i;
                dwbm_err_o = wbs_err_i | timeout_hit;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Self-checking bench for wb_ram_arbiter: reset, a table of arbitration vectors, hand-written
// write/read, mid-transfer reset and timeout sequences, then random traffic against an owner model.
module tb_wb_ram_arbiter;

    localparam int T = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef logic [138:0] vec_t;

    logic        clk;
    logic        rst_ni;
    logic [31:0] iaddr, daddr, ddat, sdat;
    logic [3:0]  dsel;
    logic        icyc, istb, dcyc, dstb, dwe, sack, serr;
    logic [31:0] iwbm_dat_o, dwbm_dat_o, wbs_addr_o, wbs_dat_o;
    logic [3:0]  wbs_sel_o;
    logic        iwbm_ack_o, iwbm_err_o, dwbm_ack_o, dwbm_err_o;
    logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus (0 none, 1 I, 2 D), who owned it last, stall length.
    int own, last, waited;

    wb_ram_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .iwbm_addr_i(iaddr), .iwbm_cyc_i(icyc), .iwbm_stb_i(istb),
        .iwbm_dat_o(iwbm_dat_o), .iwbm_ack_o(iwbm_ack_o), .iwbm_err_o(iwbm_err_o),
        .dwbm_addr_i(daddr), .dwbm_dat_i(ddat), .dwbm_sel_i(dsel),
        .dwbm_cyc_i(dcyc), .dwbm_stb_i(dstb), .dwbm_we_i(dwe),
        .dwbm_dat_o(dwbm_dat_o), .dwbm_ack_o(dwbm_ack_o), .dwbm_err_o(dwbm_err_o),
        .wbs_addr_o(wbs_addr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
        .wbs_dat_i(sdat), .wbs_ack_i(sack), .wbs_err_i(serr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t obs();
        return {wbs_addr_o, wbs_dat_o, wbs_sel_o, wbs_cyc_o, wbs_stb_o, wbs_we_o,
                iwbm_dat_o, iwbm_ack_o, iwbm_err_o, dwbm_dat_o, dwbm_ack_o, dwbm_err_o};
    endfunction

    function automatic vec_t model_out();
        logic [31:0] a = '0, w = '0;
        logic [3:0]  s = '0;
        logic c = 0, st = 0, we = 0, ia = 0, ie = 0, da = 0, de = 0, to;
        to = TO_EN && own != 0 && waited == T;
        if (own == 1) begin
            a = iaddr; s = 4'hF; c = icyc; st = istb; ia = sack; ie = serr | to;
        end else if (own == 2) begin
            a = daddr; w = ddat; s = dsel; c = dcyc; st = dstb; we = dwe; da = sack; de = serr | to;
        end
        return {a, w, s, c, st, we, sdat, ia, ie, sdat, da, de};
    endfunction

    task automatic model_reset();
        own = 0; last = 2; waited = 0;
    endtask

    task automatic model_step();
        logic ri, rd, done, to, mine_c, mine_s, other;
        ri = icyc & istb;
        rd = dcyc & dstb;
        done = sack | serr;
        if (own == 0) begin
            waited = 0;
            if (ri && rd) own = (last == 2) ? 1 : 2;
            else if (ri) own = 1;
            else if (rd) own = 2;
            if (own != 0) last = own;
        end else begin
            to     = TO_EN && waited == T;
            mine_c = (own == 1) ? icyc : dcyc;
            mine_s = (own == 1) ? istb : dstb;
            other  = (own == 1) ? rd : ri;
            if (!mine_c || (done && other) || to) begin
                own = 0; waited = 0;
            end else if (done) waited = 0;
            else if (mine_s) waited = waited + 1;
        end
    endtask

    task automatic check(input string name, input vec_t got, input vec_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic ci, input logic si, input logic cd, input logic sd,
                         input logic ack, input logic err);
        icyc = ci; istb = si; dcyc = cd; dstb = sd; sack = ack; serr = err;
    endtask

    // Called just after a falling edge with inputs set: compare, clock, step the model.
    task automatic cycle(input string name);
        #1;
        check(name, obs(), model_out());
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        logic ci, si, cd, sd, ack, err;
        int   gnt;
        logic ia, ie, da, de;
    } row_t;

    row_t tbl[16];

    initial begin
        int g;
        tbl[0]  = '{1,1,1,1,1,0, 0, 0,0,0,0};
        tbl[1]  = '{1,1,1,1,1,0, 1, 1,0,0,0};
        tbl[2]  = '{1,1,1,1,1,0, 0, 0,0,0,0};
        tbl[3]  = '{1,1,1,1,1,0, 2, 0,0,1,0};
        tbl[4]  = '{1,1,1,1,1,0, 0, 0,0,0,0};
        tbl[5]  = '{1,1,0,0,1,0, 1, 1,0,0,0};
        tbl[6]  = '{1,1,0,0,1,0, 1, 1,0,0,0};
        tbl[7]  = '{1,1,0,0,0,0, 1, 0,0,0,0};
        tbl[8]  = '{0,0,1,1,1,0, 1, 1,0,0,0};
        tbl[9]  = '{0,0,1,1,0,0, 0, 0,0,0,0};
        tbl[10] = '{0,0,1,1,0,0, 2, 0,0,0,0};
        tbl[11] = '{1,1,0,0,0,0, 2, 0,0,0,0};
        tbl[12] = '{1,1,0,0,0,0, 0, 0,0,0,0};
        tbl[13] = '{1,1,0,0,0,1, 1, 0,1,0,0};
        tbl[14] = '{0,0,0,0,0,0, 1, 0,0,0,0};
        tbl[15] = '{0,0,0,0,0,0, 0, 0,0,0,0};

        // Reset held with both masters requesting and the slave asserting ack/err.
        rst_ni = 1'b0;
        iaddr = 32'h1111_0000; daddr = 32'h2222_0000; ddat = 32'h0BAD_F00D; dsel = 4'h3;
        dwe = 1'b0; sdat = 32'h0;
        drive(1, 1, 1, 1, 1, 1);
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", obs(), '0);
        @(negedge clk);
        rst_ni = 1'b1;

        for (int r = 0; r < 16; r++) begin
            drive(tbl[r].ci, tbl[r].si, tbl[r].cd, tbl[r].sd, tbl[r].ack, tbl[r].err);
            #1;
            g = (wbs_addr_o == iaddr) ? 1 : (wbs_addr_o == daddr) ? 2 : (wbs_addr_o == 0) ? 0 : 3;
            check($sformatf("table_row%0d", r),
                  vec_t'({g[1:0], iwbm_ack_o, iwbm_err_o, dwbm_ack_o, dwbm_err_o}),
                  vec_t'({tbl[r].gnt[1:0], tbl[r].ia, tbl[r].ie, tbl[r].da, tbl[r].de}));
            @(posedge clk);
            model_step();
            @(negedge clk);
        end

        // Data write followed by instruction read of the same address.
        daddr = 32'h100; ddat = 32'hDEAD_BEEF; dsel = 4'b0101; dwe = 1'b1;
        drive(0, 0, 1, 1, 0, 0);
        cycle("dwrite_idle");
        iaddr = 32'h100;
        drive(1, 1, 1, 1, 1, 0);
        #1;
        check("dwrite_slave", vec_t'({wbs_addr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, dwbm_ack_o}),
              vec_t'({32'h100, 32'hDEAD_BEEF, 4'b0101, 1'b1, 1'b1, 1'b1}));
        cycle("dwrite_ack");
        dwe = 1'b0;
        drive(1, 1, 0, 0, 0, 0);
        cycle("iread_idle");
        sdat = 32'hDEAD_BEEF;
        drive(1, 1, 0, 0, 1, 0);
        #1;
        check("iread_data", vec_t'({iwbm_dat_o, iwbm_ack_o, wbs_we_o, wbs_sel_o}),
              vec_t'({32'hDEAD_BEEF, 1'b1, 1'b0, 4'hF}));
        cycle("iread_ack");

        // Asynchronous reset in the middle of a granted transfer.
        sdat = 32'h0;
        drive(1, 1, 0, 0, 1, 0);
        #1;
        check("rst_mid_granted", vec_t'(wbs_cyc_o), vec_t'(1'b1));
        rst_ni = 1'b0;
        #1;
        check("rst_mid_outputs", obs(), '0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        cycle("after_rst");

`ifdef ARB_TIMEOUT_EN
        // Stalled slave: error pulse on the T-th stalled cycle, then the bus drops.
        daddr = 32'h2222_0040;
        drive(0, 0, 1, 1, 0, 0);
        cycle("to_idle");
        for (int k = 0; k <= T; k++) begin
            #1;
            check($sformatf("to_err_k%0d", k), vec_t'(dwbm_err_o), vec_t'(k == T));
            cycle("to_stall");
        end
        #1;
        check("to_cyc_drop", vec_t'(wbs_cyc_o), vec_t'(1'b0));
        drive(0, 0, 0, 0, 0, 0);
        cycle("to_release");
`endif

        // Random traffic against the owner model.
        for (int n = 0; n < 400; n++) begin
            iaddr = $urandom; daddr = $urandom; ddat = $urandom; sdat = $urandom;
            dsel  = 4'($urandom_range(0, 15));
            dwe   = 1'($urandom_range(0, 1));
            icyc  = ($urandom_range(0, 3) != 0);
            istb  = icyc & ($urandom_range(0, 3) != 0);
            dcyc  = ($urandom_range(0, 3) != 0);
            dstb  = dcyc & ($urandom_range(0, 3) != 0);
            sack  = ($urandom_range(0, 2) == 0);
            serr  = !sack && ($urandom_range(0, 15) == 0);
            cycle("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_ram_arbiter.md
# wb_ram_arbiter

Two-master to one-slave Wishbone arbiter that shares a single-port memory between the core's instruction fetch port and data port. It sits between the core's instruction and data Wishbone masters and one memory slave. It serialises their accesses with a registered round-robin grant and optionally aborts stalled transfers with a bus-error timeout.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles a granted strobe may wait for ack/err before timeout. Legal range 1..65535. Used only with `ARB_TIMEOUT_EN`.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `iwbm_addr_i` in 32: instruction master address.
- `iwbm_cyc_i`, `iwbm_stb_i` in 1 each: instruction master cycle and strobe.
- `iwbm_dat_o` out 32: instruction read data.
- `iwbm_ack_o`, `iwbm_err_o` out 1 each: instruction acknowledge and error.
- `dwbm_addr_i` in 32, `dwbm_dat_i` in 32, `dwbm_sel_i` in 4: data master address, write data and byte select.
- `dwbm_cyc_i`, `dwbm_stb_i`, `dwbm_we_i` in 1 each: data master cycle, strobe and write enable.
- `dwbm_dat_o` out 32: data read data.
- `dwbm_ack_o`, `dwbm_err_o` out 1 each: data acknowledge and error.
- `wbs_addr_o` out 32, `wbs_dat_o` out 32, `wbs_sel_o` out 4: slave address, write data and byte select.
- `wbs_cyc_o`, `wbs_stb_o`, `wbs_we_o` out 1 each: slave cycle, strobe and write enable.
- `wbs_dat_i` in 32: slave read data.
- `wbs_ack_i`, `wbs_err_i` in 1 each: slave acknowledge and error.

## Operation
- FSM states: `IDLE`, `BUS_I`, `BUS_D`. Reset state is `IDLE`. A `last_grant` register resets to D, so I wins the first tie.
- Request: `req_x = xwbm_cyc_i & xwbm_stb_i`.
- `IDLE` transitions:
  - Only `req_i`: go to `BUS_I`.
  - Only `req_d`: go to `BUS_D`.
  - Both: grant the master not equal to `last_grant`.
  - `last_grant` updates on entry to `BUS_x`.
- `BUS_I`:
  - Slave address/cyc/stb come from the I master.
  - `wbs_we_o`=0, `wbs_sel_o`=4'hF, `wbs_dat_o`=0.
- `BUS_D`: all slave request signals come from the D master.
- Granted master: `ack_o`/`err_o` = `wbs_ack_i`/`wbs_err_i`, combinational.
- Non-granted master: `ack_o`/`err_o` = 0.
- Both masters' `dat_o` = `wbs_dat_i` at all times.
- Not granted (`IDLE`): `wbs_cyc_o`, `wbs_stb_o`, `wbs_we_o` = 0; `wbs_addr_o`, `wbs_dat_o`, `wbs_sel_o` = 0.
- Release from `BUS_x` to `IDLE` in the same cycle when any of the following holds:
  - Granted master drops `cyc` (abort, with or without ack).
  - `wbs_ack_i` or `wbs_err_i` is high and the other master is requesting.
  - `wbs_ack_i` or `wbs_err_i` is high and the granted master drops `cyc`.
- Otherwise the grant is held, which permits back-to-back accesses by one master while the other is idle.
- A request arriving during `IDLE` wins only on the next edge. No same-cycle grant from `IDLE`.

## Timing
- Reset values: state `IDLE`, `last_grant`=D, timeout counter 0; all `wbs_*` outputs 0; all master `ack_o`/`err_o` 0.
- Grant latency: a request sampled in cycle N drives `wbs_cyc_o`/`wbs_stb_o` in cycle N+1.
- With a combinational-ack slave, a master sees ack in N+1. Minimum 2 cycles per arbitrated access.
- Back-to-back accesses under a held grant: 1 access per cycle.
- Alternating contention: I, D, I, D, with one `IDLE` cycle between grants.
- Reset mid-transfer: outputs drop to reset values immediately (asynchronous); the transfer is lost.
- Simultaneous ack and abort (`cyc` low): the ack is still forwarded; the next state is `IDLE`.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on grant entry and on every ack/err.
  - It increments each cycle the granted strobe is high without ack/err.
  - When it equals `TIMEOUT_CYCLES`, the granted master's `err_o` is forced high for exactly that cycle, the FSM goes to `IDLE`, and `wbs_cyc_o` drops on the next cycle.
  - `last_grant` is unchanged, so the other master wins the next tie.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is instantiated.
  - `err_o` is a pure passthrough of `wbs_err_i`.
  - `TIMEOUT_CYCLES` is ignored.
  - A stalled slave holds the grant indefinitely.

## Test plan
- Reset: hold `rst_ni`=0 with both requests high -> all `wbs_*` and master `ack`/`err` are 0. Release -> `BUS_I` one cycle later with `wbs_addr_o`=`iwbm_addr_i`.
- Simultaneous persistent requests, combinational-ack slave -> grants I, D, I, D. Each master acks every 2nd access, with an `IDLE` cycle between grants.
- D write: addr 0x100, dat 0xDEADBEEF, sel 4'b0101 -> slave sees `we`=1, sel 0101 and the same addr/dat. A subsequent I read of 0x100 gets `iwbm_dat_o`=`wbs_dat_i`.
- I alone holds `cyc` for 4 accesses -> 4 acks in 4 consecutive cycles after grant; `dwbm_ack_o` stays 0.
- Abort: D granted, slave never acks, D drops `cyc` -> `IDLE` next cycle; a pending I request is granted the cycle after.
- With `ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, slave never acks -> `dwbm_err_o` pulses high for 1 cycle when the counter reaches 4, then `wbs_cyc_o`=0.
